max_pool_ctrl: RTL and testbench



---
 rtl/max_pool_pkg.sv | 30 +++
 rtl/max_pool_ctrl_if.sv | 32 +++
 rtl/max_pool_addr_gen.sv | 94 +++++++++
 rtl/max_pool_ctrl.sv | 113 +++++++++++
 tb/tb_max_pool_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/max_pool_pkg.sv
// Shared types and size helpers for the max-pooling controller.
// The fused-ReLU option is selected in the top by MAX_POOL_RELU_EN.
package max_pool_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } pool_state_t;

   // Counter/address width for n distinct values, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Pooled dimension: trailing rows/columns that do not fill a window are dropped.
   function automatic int out_dim(input int d, input int s);
      return d / s;
   endfunction

   function automatic int in_addr_w(input int c, input int h, input int w);
      return cnt_w(c * h * w);
   endfunction

   function automatic int out_addr_w(input int c, input int h, input int w, input int s);
      return cnt_w(c * out_dim(h, s) * out_dim(w, s));
   endfunction

endpackage

// File: rtl/max_pool_ctrl_if.sv
// Bus between the layer sequencer / feature-map RAMs and the max-pool controller.
interface max_pool_ctrl_if #(
   parameter int bitwidth = 8,
   parameter int in_aw    = max_pool_pkg::in_addr_w(2, 24, 24),
   parameter int out_aw   = max_pool_pkg::out_addr_w(2, 24, 24, 2)
) ();
   import max_pool_pkg::*;

   // start is a one-cycle request honoured only while idle; rd_data answers
   // rd_en exactly one cycle later; wr_en is a strobe with no backpressure.
   logic                start;
   logic                busy;
   logic                done;
   logic                rd_en;
   logic [in_aw-1:0]    rd_addr;
   logic [bitwidth-1:0] rd_data;
   logic                wr_en;
   logic [out_aw-1:0]   wr_addr;
   logic [bitwidth-1:0] wr_data;
   pool_state_t         state;

   modport master (
      input  start, rd_data,
      output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, state
   );

   modport slave (
      output start, rd_data,
      input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, state
   );

endinterface

// File: rtl/max_pool_addr_gen.sv
// Nested channel/row/col/window counters producing input and pooled addresses.
module max_pool_addr_gen
   import max_pool_pkg::*;
#(
   parameter int datawidth   = 24,
   parameter int dataheight  = 24,
   parameter int datachannel = 2,
   parameter int scale       = 2,
   parameter int in_aw       = in_addr_w(datachannel, dataheight, datawidth),
   parameter int out_aw      = out_addr_w(datachannel, dataheight, datawidth, scale)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              step_rd,
   input  logic              step_win,
   output logic [in_aw-1:0]  rd_addr,
   output logic [out_aw-1:0] wr_addr,
   output logic              first_elem,
   output logic              last_elem,
   output logic              last_win
);

   localparam int ho = out_dim(dataheight, scale);
   localparam int wo = out_dim(datawidth, scale);
   localparam int cw = cnt_w(datachannel);
   localparam int jw = cnt_w(ho);
   localparam int kw = cnt_w(wo);
   localparam int sw = cnt_w(scale);

   logic [cw-1:0] c_q;
   logic [jw-1:0] j_q;
   logic [kw-1:0] k_q;
   logic [sw-1:0] m_q, n_q;
   logic c_last, j_last, k_last, m_last, n_last;

   assign c_last = (c_q == cw'(datachannel - 1));
   assign j_last = (j_q == jw'(ho - 1));
   assign k_last = (k_q == kw'(wo - 1));
   assign m_last = (m_q == sw'(scale - 1));
   assign n_last = (n_q == sw'(scale - 1));

   assign first_elem = (m_q == '0) && (n_q == '0);
   assign last_elem  = m_last && n_last;
   assign last_win   = c_last && j_last && k_last;

   // Every counter wraps to zero, so the addresses rest at 0 between passes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q <= '0;
         j_q <= '0;
         k_q <= '0;
         m_q <= '0;
         n_q <= '0;
      end else if (clear) begin
         c_q <= '0;
         j_q <= '0;
         k_q <= '0;
         m_q <= '0;
         n_q <= '0;
      end else begin
         if (step_rd) begin
            if (n_last) begin
               n_q <= '0;
               m_q <= m_last ? '0 : m_q + sw'(1);
            end else begin
               n_q <= n_q + sw'(1);
            end
         end
         if (step_win) begin
            if (k_last) begin
               k_q <= '0;
               if (j_last) begin
                  j_q <= '0;
                  c_q <= c_last ? '0 : c_q + cw'(1);
               end else begin
                  j_q <= j_q + jw'(1);
               end
            end else begin
               k_q <= k_q + kw'(1);
            end
         end
      end
   end

   assign rd_addr = in_aw'(c_q) * in_aw'(dataheight * datawidth)
                  + (in_aw'(j_q) * in_aw'(scale) + in_aw'(m_q)) * in_aw'(datawidth)
                  + in_aw'(k_q) * in_aw'(scale) + in_aw'(n_q);

   assign wr_addr = out_aw'(c_q) * out_aw'(ho * wo)
                  + out_aw'(j_q) * out_aw'(wo)
                  + out_aw'(k_q);

endmodule

// File: rtl/max_pool_ctrl.sv
// Max-pooling sequencer: one read per cycle, one write per window, shared comparator.
// Define MAX_POOL_RELU_EN to clamp negative window maxima to zero on write.
module max_pool_ctrl
   import max_pool_pkg::*;
#(
   parameter int bitwidth    = 8,
   parameter int datawidth   = 24,
   parameter int dataheight  = 24,
   parameter int datachannel = 2,
   parameter int scale       = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   max_pool_ctrl_if.master bus
);

   localparam int in_aw  = in_addr_w(datachannel, dataheight, datawidth);
   localparam int out_aw = out_addr_w(datachannel, dataheight, datawidth, scale);

   pool_state_t state_q, state_d;
   logic clear, step_rd, step_win;
   logic first_elem, last_elem, last_win;
   logic [in_aw-1:0]  rd_addr;
   logic [out_aw-1:0] wr_addr;
   logic rd_valid_q, rd_first_q;
   logic signed [bitwidth-1:0] acc_q, rd_word, pool_max, pool_out;

   max_pool_addr_gen #(
      .datawidth   (datawidth),
      .dataheight  (dataheight),
      .datachannel (datachannel),
      .scale       (scale),
      .in_aw       (in_aw),
      .out_aw      (out_aw)
   ) u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .step_rd    (step_rd),
      .step_win   (step_win),
      .rd_addr    (rd_addr),
      .wr_addr    (wr_addr),
      .first_elem (first_elem),
      .last_elem  (last_elem),
      .last_win   (last_win)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      clear    = 1'b0;
      step_rd  = 1'b0;
      step_win = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               clear   = 1'b1;
               state_d = READ;
            end
         end
         READ: begin
            step_rd = 1'b1;
            if (last_elem) state_d = WRITE;
         end
         WRITE: begin
            step_win = 1'b1;
            state_d  = last_win ? DONE : READ;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The final word of a window lands during WRITE and is folded in combinationally.
   assign rd_word  = $signed(bus.rd_data);
   assign pool_max = (rd_word > acc_q) ? rd_word : acc_q;

`ifdef MAX_POOL_RELU_EN
   assign pool_out = pool_max[bitwidth-1] ? '0 : pool_max;
`else
   assign pool_out = pool_max;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_first_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         rd_first_q <= bus.rd_en && first_elem;
         if (clear) begin
            acc_q <= '0;
         end else if (rd_valid_q && (rd_first_q || (rd_word > acc_q))) begin
            acc_q <= rd_word;
         end
      end
   end

   assign bus.busy    = (state_q == READ) || (state_q == WRITE);
   assign bus.done    = (state_q == DONE);
   assign bus.rd_en   = (state_q == READ);
   assign bus.wr_en   = (state_q == WRITE);
   assign bus.rd_addr = rd_addr;
   assign bus.wr_addr = wr_addr;
   assign bus.wr_data = bus.wr_en ? pool_out : '0;
   assign bus.state   = state_q;

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Bench for max_pool_ctrl: three geometries share one input memory and one scoreboard.
module tb_max_pool_ctrl;
   import max_pool_pkg::*;

   localparam int bw   = 8;
   localparam int a_iw = in_addr_w(1, 4, 4);
   localparam int a_ow = out_addr_w(1, 4, 4, 2);
   localparam int b_iw = in_addr_w(2, 4, 4);
   localparam int b_ow = out_addr_w(2, 4, 4, 2);
   localparam int c_iw = in_addr_w(1, 5, 5);
   localparam int c_ow = out_addr_w(1, 5, 5, 2);

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   int   sel   = 0;
   always #5 clk = ~clk;

   max_pool_ctrl_if #(.bitwidth(bw), .in_aw(a_iw), .out_aw(a_ow)) bus_a ();
   max_pool_ctrl_if #(.bitwidth(bw), .in_aw(b_iw), .out_aw(b_ow)) bus_b ();
   max_pool_ctrl_if #(.bitwidth(bw), .in_aw(c_iw), .out_aw(c_ow)) bus_c ();

   max_pool_ctrl #(.bitwidth(bw), .datawidth(4), .dataheight(4), .datachannel(1), .scale(2))
      u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   max_pool_ctrl #(.bitwidth(bw), .datawidth(4), .dataheight(4), .datachannel(2), .scale(2))
      u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
   max_pool_ctrl #(.bitwidth(bw), .datawidth(5), .dataheight(5), .datachannel(1), .scale(2))
      u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

   assign bus_a.start = start && (sel == 0);
   assign bus_b.start = start && (sel == 1);
   assign bus_c.start = start && (sel == 2);

   // input feature-map RAM, one-cycle read latency
   logic signed [7:0] mem [32];
   always @(posedge clk) if (bus_a.rd_en) bus_a.rd_data <= mem[bus_a.rd_addr];
   always @(posedge clk) if (bus_b.rd_en) bus_b.rd_data <= mem[bus_b.rd_addr];
   always @(posedge clk) if (bus_c.rd_en) bus_c.rd_data <= mem[bus_c.rd_addr];

   logic m_busy, m_done, m_rd_en, m_wr_en;
   int m_rd_addr, m_wr_addr;
   logic [7:0] m_wr_data;
   always_comb begin
      m_busy    = bus_a.busy;
      m_done    = bus_a.done;
      m_rd_en   = bus_a.rd_en;
      m_wr_en   = bus_a.wr_en;
      m_rd_addr = int'(bus_a.rd_addr);
      m_wr_addr = int'(bus_a.wr_addr);
      m_wr_data = bus_a.wr_data;
      if (sel == 1) begin
         m_busy    = bus_b.busy;
         m_done    = bus_b.done;
         m_rd_en   = bus_b.rd_en;
         m_wr_en   = bus_b.wr_en;
         m_rd_addr = int'(bus_b.rd_addr);
         m_wr_addr = int'(bus_b.wr_addr);
         m_wr_data = bus_b.wr_data;
      end else if (sel == 2) begin
         m_busy    = bus_c.busy;
         m_done    = bus_c.done;
         m_rd_en   = bus_c.rd_en;
         m_wr_en   = bus_c.wr_en;
         m_rd_addr = int'(bus_c.rd_addr);
         m_wr_addr = int'(bus_c.wr_addr);
         m_wr_data = bus_c.wr_data;
      end
   end

   // scoreboard
   logic [15:0] exp_q[$];
   bit legal [32];
   bit seen  [32];
   int n_pass = 0;
   int n_total = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int wr_cnt = 0;
   logic [7:0] wr0_data;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference: every window's maximum straight from the address formulas.
   task automatic model(input int c_n, input int h, input int w, input int s);
      int ho, wo, a, mx;
      ho = h / s;
      wo = w / s;
      exp_q.delete();
      foreach (legal[i]) legal[i] = 1'b0;
      for (int c = 0; c < c_n; c++)
         for (int j = 0; j < ho; j++)
            for (int k = 0; k < wo; k++) begin
               mx = -1000;
               for (int m = 0; m < s; m++)
                  for (int n = 0; n < s; n++) begin
                     a = c * h * w + (j * s + m) * w + k * s + n;
                     legal[a] = 1'b1;
                     if (int'(mem[a]) > mx) mx = int'(mem[a]);
                  end
`ifdef MAX_POOL_RELU_EN
               if (mx < 0) mx = 0;
`endif
               exp_q.push_back({8'(c * ho * wo + j * wo + k), 8'(mx)});
            end
   endtask

   always @(negedge clk) begin
      logic [15:0] e;
      if (rst_n) begin
         if (m_busy) busy_cnt++;
         if (m_done) begin
            done_cnt++;
            check("done_while_busy", int'(m_busy), 0);
         end
         if (m_rd_en) begin
            check("rd_in_window", int'(legal[m_rd_addr]), 1);
            check("rd_no_repeat", int'(seen[m_rd_addr]), 0);
            if (m_rd_addr >= 0 && m_rd_addr < 32) seen[m_rd_addr] = 1'b1;
         end
         if (m_wr_en) begin
            wr_cnt++;
            check("wr_rd_overlap", int'(m_rd_en), 0);
            if (m_wr_addr == 0) wr0_data = m_wr_data;
            check("wr_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("wr_addr", m_wr_addr, int'(e[15:8]));
               check("wr_data", int'(m_wr_data), int'(e[7:0]));
            end
         end
      end
   end

   // driver tasks
   task automatic clear_stats();
      busy_cnt = 0;
      done_cnt = 0;
      wr_cnt   = 0;
      foreach (seen[i]) seen[i] = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_idle_a(input string tag);
      check({tag, "_busy"},    int'(bus_a.busy), 0);
      check({tag, "_done"},    int'(bus_a.done), 0);
      check({tag, "_rd_en"},   int'(bus_a.rd_en), 0);
      check({tag, "_wr_en"},   int'(bus_a.wr_en), 0);
      check({tag, "_rd_addr"}, int'(bus_a.rd_addr), 0);
      check({tag, "_wr_addr"}, int'(bus_a.wr_addr), 0);
      check({tag, "_wr_data"}, int'(bus_a.wr_data), 0);
      check({tag, "_state"},   int'(bus_a.state), int'(IDLE));
   endtask

   task automatic run_pass(input string tag, input int exp_busy, input int exp_wr, input bit restart);
      bit ok;
      clear_stats();
      pulse_start();
      if (restart) begin
         @(negedge clk);
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (m_done) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, int'(ok), 1);
      repeat (3) @(negedge clk);
      check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_writes"}, wr_cnt, exp_wr);
      check({tag, "_left_expected"}, exp_q.size(), 0);
   endtask

   initial begin
      int pin_a [4];
      int pin_c [4];
      int exp_neg, v;
      pin_a = '{5, 7, 13, 15};
      pin_c = '{-22, -16, 8, 14};
`ifdef MAX_POOL_RELU_EN
      exp_neg = 0;
`else
      exp_neg = 8'hFF;
`endif

      #1;
      check_idle_a("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_a("post_reset");

      // raster 0..15, single channel
      sel = 0;
      for (int i = 0; i < 32; i++) mem[i] = 8'(i);
      model(1, 4, 4, 2);
      for (int i = 0; i < 4; i++) check("model_pin_raster", int'(exp_q[i]), (i << 8) | pin_a[i]);
      run_pass("raster", 20, 4, 1'b0);

      // all-negative first window
      mem[0] = -8'sd3;
      mem[1] = -8'sd1;
      mem[4] = -8'sd7;
      mem[5] = -8'sd2;
      model(1, 4, 4, 2);
      check("model_pin_neg", int'(exp_q[0][7:0]), exp_neg);
      wr0_data = 8'h55;
      run_pass("neg", 20, 4, 1'b0);
      check("neg_wr0", int'(wr0_data), exp_neg);

      // two channels, channel 1 = channel 0 + 16
      sel = 1;
      for (int i = 0; i < 32; i++) mem[i] = 8'(i);
      model(2, 4, 4, 2);
      check("model_pin_two_ch_len", exp_q.size(), 8);
      for (int i = 0; i < 4; i++)
         check("model_pin_two_ch", int'(exp_q[4 + i]), ((4 + i) << 8) | (pin_a[i] + 16));
      run_pass("two_ch", 40, 8, 1'b0);

      // 5x5 map: row 4 and column 4 hold the largest values and must never be read
      sel = 2;
      for (int i = 0; i < 32; i++) mem[i] = ((i % 5) == 4 || i >= 20) ? 8'sd127 : 8'(i * 3 - 40);
      model(1, 5, 5, 2);
      check("model_pin_odd_len", exp_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         v = pin_c[i];
`ifdef MAX_POOL_RELU_EN
         if (v < 0) v = 0;
`endif
         check("model_pin_odd", int'(exp_q[i]), (i << 8) | (v & 8'hFF));
      end
      run_pass("odd", 20, 4, 1'b0);

      // second start mid-pass is ignored
      sel = 0;
      for (int i = 0; i < 32; i++) mem[i] = 8'(i);
      model(1, 4, 4, 2);
      run_pass("restart", 20, 4, 1'b1);

      // reset in cycle 7 of a pass, then a clean pass
      model(1, 4, 4, 2);
      clear_stats();
      pulse_start();
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_a("mid_reset");
      check("abort_writes", wr_cnt, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_no_wr", int'(bus_a.wr_en), 0);
         check("reset_no_rd", int'(bus_a.rd_en), 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_abort_no_wr", int'(bus_a.wr_en), 0);
         check("post_abort_idle", int'(bus_a.busy), 0);
      end
      model(1, 4, 4, 2);
      run_pass("after_reset", 20, 4, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
